// File: rtl/pulse_modulator_pkg.sv
// Shared constants for the pulse modulator: frame framing bits, FSM state type,
// and the MOD_PARAMS message layout used by the UART command decoder.
package pulse_modulator_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CTR_WIDTH_DEF  = 16;

  // MOD_PARAMS layout mirrors DEMOD_PARAMS so one UART message can drive both blocks.
  localparam int MOD_PARAMS_SIZE = 2 * CTR_WIDTH_DEF;
  localparam int MOD_PW_LSB      = 0;
  localparam int MOD_PW_MSB      = CTR_WIDTH_DEF - 1;
  localparam int MOD_BP_LSB      = CTR_WIDTH_DEF;
  localparam int MOD_BP_MSB      = 2 * CTR_WIDTH_DEF - 1;

  localparam logic FRAME_START_BIT = 1'b1;
  localparam logic FRAME_STOP_BIT  = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } mod_state_e;

endpackage

// File: rtl/pulse_modulator_slot_timer.sv
// Slot timing for the pulse modulator: latches the clamped period/width at accept
// and reports slot boundaries and whether the next clock lies inside the pulse.
module pulse_slot_timer #(
  parameter int CTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic [CTR_WIDTH-1:0] pulse_width_i,
  input  logic [CTR_WIDTH-1:0] bit_period_i,
  output logic                 slot_end_o,
  output logic                 in_pulse_o
);

  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);
  localparam logic [CTR_WIDTH-1:0] CTR_TWO = CTR_WIDTH'(2);

  logic [CTR_WIDTH-1:0] slot_ctr_q, slot_ctr_d;
  logic [CTR_WIDTH-1:0] bp_eff_q, bp_eff_d;
  logic [CTR_WIDTH-1:0] pw_eff_q, pw_eff_d;
  logic [CTR_WIDTH-1:0] ctr_next_s;

  // Clamp so a slot is never shorter than 2 clocks and a pulse always leaves a low clock.
  always_comb begin
    bp_eff_d = (bit_period_i < CTR_TWO) ? CTR_TWO : bit_period_i;
    pw_eff_d = (pulse_width_i > (bp_eff_d - CTR_ONE)) ? (bp_eff_d - CTR_ONE) : pulse_width_i;
    slot_end_o = (slot_ctr_q == (bp_eff_q - CTR_ONE));
    ctr_next_s = slot_end_o ? '0 : (slot_ctr_q + CTR_ONE);
    in_pulse_o = (ctr_next_s < pw_eff_q);
    if (load_i) begin
      slot_ctr_d = '0;
    end else if (run_i) begin
      slot_ctr_d = ctr_next_s;
    end else begin
      slot_ctr_d = slot_ctr_q;
    end
  end

  // Counter and latched configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_ctr_q <= '0;
      bp_eff_q   <= CTR_TWO;
      pw_eff_q   <= '0;
    end else begin
      slot_ctr_q <= slot_ctr_d;
      if (load_i) begin
        bp_eff_q <= bp_eff_d;
        pw_eff_q <= pw_eff_d;
      end
    end
  end

endmodule

// File: rtl/pulse_modulator.sv
// Serialises handshaked words into a framed pulse train: start '1', data LSB first,
// stop '0'; each '1' slot begins with a pulse of the latched width.
module pulse_modulator
  import pulse_modulator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CTR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTR_WIDTH-1:0]  pulse_width,
  input  logic [CTR_WIDTH-1:0]  bit_period,
  output logic                  out,
  output logic                  busy
);

  localparam int FRAME_BITS = DATA_WIDTH + 2;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  mod_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  out_q, out_d;
  logic                  accept_s, run_s, slot_end_s, in_pulse_s, last_slot_s;

  assign accept_s    = in_valid && (state_q == ST_IDLE);
  assign run_s       = (state_q == ST_SLOT);
  assign last_slot_s = slot_end_s && (bit_idx_q == LAST_IDX);

  pulse_slot_timer #(.CTR_WIDTH(CTR_WIDTH)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .load_i        (accept_s),
    .run_i         (run_s),
    .pulse_width_i (pulse_width),
    .bit_period_i  (bit_period),
    .slot_end_o    (slot_end_s),
    .in_pulse_o    (in_pulse_s)
  );

  // State, shift register, bit index and the registered pulse output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_idx_q <= '0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_idx_q <= bit_idx_d;
      out_q     <= out_d;
    end
  end

  // Next state plus frame shift register and slot index.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_SLOT;
          sr_d      = {FRAME_STOP_BIT, in_data, FRAME_START_BIT};
          bit_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SLOT: begin
        if (slot_end_s) begin
          sr_d = {1'b0, sr_q[FRAME_BITS-1:1]};
          if (last_slot_s) begin
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_SLOT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; the start pulse rises on the accept edge itself.
  always_comb begin
    out_d    = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept_s) begin
          out_d = (pulse_width != '0);
        end else begin
          out_d = 1'b0;
        end
      end
      ST_SLOT: begin
        busy = 1'b1;
        if (last_slot_s) begin
          out_d = 1'b0;
        end else if (slot_end_s) begin
          out_d = sr_q[1] && in_pulse_s;
        end else begin
          out_d = sr_q[0] && in_pulse_s;
        end
      end
      default: out_d = 1'b0;
    endcase
  end

  assign out = out_q;

endmodule

// File: tb/tb_pulse_modulator.sv
// Directed bench for pulse_modulator: samples on the falling edge, expected
// waveforms derived from the frame word, slot length and clamped pulse width.
module tb_pulse_modulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pulse_width;
  logic [15:0] bit_period;
  logic        out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_modulator #(.DATA_WIDTH(8), .CTR_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pulse_width (pulse_width),
    .bit_period  (bit_period),
    .out         (out),
    .busy        (busy)
  );

  // Expected out in cycle n after the accept edge, given effective period/width.
  function automatic logic exp_out(input logic [7:0] data, input int n, input int bp, input int pw);
    logic [9:0] frame;
    frame = {1'b0, data, 1'b1};
    if (n < 0 || n >= 10 * bp) return 1'b0;
    return frame[n / bp] && ((n % bp) < pw);
  endfunction

  // Present a word for one accept edge; returns at the falling edge of cycle 0.
  task automatic start_frame(input logic [7:0] d, input logic [15:0] pw, input logic [15:0] bp);
    @(negedge clk);
    in_data = d; pulse_width = pw; bit_period = bp; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; pulse_width = 16'd3; bit_period = 16'd10;
    repeat (3) @(negedge clk);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic_frame();
    start_frame(8'hA5, 16'd3, 16'd10);
    for (int n = 0; n <= 100; n++) begin
      checks++; if (out !== exp_out(8'hA5, n, 10, 3)) begin errors++; $display("FAIL basic_out c%0d: got %b expected %b", n, out, exp_out(8'hA5, n, 10, 3)); end
      checks++; if (busy !== (n < 100)) begin errors++; $display("FAIL basic_busy c%0d: got %b expected %b", n, busy, (n < 100)); end
      checks++; if (in_ready !== (n >= 100)) begin errors++; $display("FAIL basic_ready c%0d: got %b expected %b", n, in_ready, (n >= 100)); end
      @(negedge clk);
    end
  endtask

  task automatic test_clamping();
    start_frame(8'hFF, 16'd5, 16'd1);
    for (int n = 0; n <= 20; n++) begin
      checks++; if (out !== exp_out(8'hFF, n, 2, 1)) begin errors++; $display("FAIL clamp_out c%0d: got %b expected %b", n, out, exp_out(8'hFF, n, 2, 1)); end
      checks++; if (busy !== (n < 20)) begin errors++; $display("FAIL clamp_busy c%0d: got %b expected %b", n, busy, (n < 20)); end
      @(negedge clk);
    end
  endtask

  task automatic test_silent();
    start_frame(8'hFF, 16'd0, 16'd4);
    for (int n = 0; n <= 40; n++) begin
      checks++; if (out !== 1'b0) begin errors++; $display("FAIL silent_out c%0d: got %b expected 0", n, out); end
      checks++; if (busy !== (n < 40)) begin errors++; $display("FAIL silent_busy c%0d: got %b expected %b", n, busy, (n < 40)); end
      checks++; if (in_ready !== (n >= 40)) begin errors++; $display("FAIL silent_ready c%0d: got %b expected %b", n, in_ready, (n >= 40)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int second;
    logic e;
    second = -1;
    @(negedge clk);
    in_data = 8'h01; pulse_width = 16'd2; bit_period = 16'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h80;
    for (int n = 0; n <= 81; n++) begin
      e = (n <= 40) ? exp_out(8'h01, n, 4, 2) : exp_out(8'h80, n - 41, 4, 2);
      checks++; if (out !== e) begin errors++; $display("FAIL b2b_out c%0d: got %b expected %b", n, out, e); end
      if (in_ready === 1'b1 && second < 0) second = n;
      if (n == 41) in_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (second != 40) begin errors++; $display("FAIL b2b_spacing: accept edge at cycle %0d expected 41", second + 1); end
  endtask

  task automatic test_config_change();
    start_frame(8'hFF, 16'd3, 16'd10);
    for (int n = 0; n <= 100; n++) begin
      checks++; if (out !== exp_out(8'hFF, n, 10, 3)) begin errors++; $display("FAIL cfg_old_out c%0d: got %b expected %b", n, out, exp_out(8'hFF, n, 10, 3)); end
      if (n == 25) pulse_width = 16'd7;
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n <= 100; n++) begin
      checks++; if (out !== exp_out(8'hFF, n, 10, 7)) begin errors++; $display("FAIL cfg_new_out c%0d: got %b expected %b", n, out, exp_out(8'hFF, n, 10, 7)); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'hA5, 16'd3, 16'd10);
    repeat (12) @(negedge clk);
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL rstmid_pre_out: got %b expected 1", out); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %b expected 0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    start_frame(8'h00, 16'd2, 16'd4);
    for (int n = 0; n <= 40; n++) begin
      checks++; if (out !== exp_out(8'h00, n, 4, 2)) begin errors++; $display("FAIL rstmid_next_out c%0d: got %b expected %b", n, out, exp_out(8'h00, n, 4, 2)); end
      checks++; if (busy !== (n < 40)) begin errors++; $display("FAIL rstmid_next_busy c%0d: got %b expected %b", n, busy, (n < 40)); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamping();
    test_silent();
    test_back_to_back();
    test_config_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_modulator.md
Name: pulse_modulator

Overview:
- Upstream neighbour of the demodulator in the delay-line test harness.
- Serialises data words received over a valid/ready handshake into a framed pulse train that drives the delay line under test.
- Each bit slot lasts bit_period clocks. A '1' bit emits a pulse of pulse_width clocks at the start of its slot; a '0' bit emits nothing.
- The demodulator at the far end re-stretches the received pulses.

Parameters:
- DATA_WIDTH, 8, bits per word, sent LSB first.
- CTR_WIDTH, 16, width of the pulse_width, bit_period and slot counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  DATA_WIDTH  word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- pulse_width  input  CTR_WIDTH  pulse length in clocks; sampled at accept
- bit_period  input  CTR_WIDTH  slot length in clocks; sampled at accept
- out  output  1  registered pulse output to the delay line
- busy  output  1  a frame is in progress

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE, out=0, busy=0, in_ready=1 on the following cycle.
  - Applied mid-frame, it aborts the frame: out is low after the reset edge and the word is discarded.
- Frame format, each slot bit_period_eff clocks:
  - start slot: always '1'
  - DATA_WIDTH data slots, LSB first
  - one stop slot: always '0'
  - Frame length = (DATA_WIDTH+2)*bit_period_eff clocks.
- Effective values are computed and latched on the accept edge:
  - bit_period_eff = max(bit_period, 2)
  - pw_eff = min(pulse_width, bit_period_eff-1), so consecutive '1's always have at least one low clock between them.
  - pulse_width=0 means every slot is silent, including the start slot.
  - Input changes mid-frame have no effect.
- FSM states:
  - IDLE: in_ready=1, busy=0. On in_valid && in_ready at edge E0:
    - load shift register {1'b0, in_data, 1'b1}
    - latch the effective config
    - slot_ctr=0, bit_idx=0
    - out<=(pw_eff!=0), i.e. the start pulse rises on the accept edge itself
    - go to SLOT.
  - SLOT: in_ready=0, busy=1.
    - slot_ctr increments every clock.
    - out <= cur_bit && (next slot_ctr < pw_eff).
    - When slot_ctr == bit_period_eff-1: slot_ctr<=0 and the shift register shifts.
      - If bit_idx == DATA_WIDTH+1, go to IDLE with out<=0.
      - Otherwise bit_idx++ and out <= next_bit && (pw_eff!=0).
- Timing:
  - Rising edges of out fall exactly bit_period_eff*k clocks after E0.
  - in_ready reasserts in the cycle after edge E0+(DATA_WIDTH+2)*bit_period_eff.
  - Minimum accept-to-accept spacing is (DATA_WIDTH+2)*bit_period_eff+1 clocks.
- Handshake:
  - in_valid may be held across a frame; it is not consumed until IDLE.
  - in_data is sampled only on the accept edge.
  - in_valid while not ready is ignored, with no error flag.
- Width rules:
  - All counters are CTR_WIDTH bits; comparisons are unsigned.
  - bit_idx is clog2(DATA_WIDTH+2) bits.
  - No counter can wrap, since slot_ctr < bit_period_eff ≤ 2^CTR_WIDTH-1.

Decomposition:
- Shared constants header, alongside the existing UART message constants:
  - MOD_PARAMS size/bit-slice macros for pulse_width and bit_period, matching the demodulator's DEMOD_PARAMS layout, so the UART command decoder can drive both blocks from one message.
  - Frame constants: start=1, stop=0.
- One natural sub-module, pulse_slot_timer:
  - Holds slot_ctr, bit_period_eff and pw_eff.
  - Outputs slot_end and in_pulse.
  - The top level keeps the FSM, shift register and handshake.

Test Plan:
- Basic frame: reset, then DATA_WIDTH=8, bit_period=10, pulse_width=3, in_data=0xA5 accepted at E0 -> out high during cycles [0,3), [10,13), [30,33), [60,63), [80,83) relative to E0 and low elsewhere; busy=1 for 100 cycles; in_ready=1 at cycle 100.
- Clamping: bit_period=1, pulse_width=5, in_data=0xFF -> bit_period_eff=2 and pw_eff=1; out toggles 1,0 for 9 slots then is low for the stop slot; frame is 20 cycles.
- Silent frame: pulse_width=0, in_data=0xFF, bit_period=4 -> out stays 0 for all 40 cycles; busy=1 for 40 cycles; handshake completes normally.
- Back-to-back: in_valid held high with 0x01 then 0x80, bit_period=4, pulse_width=2 -> second accept exactly 41 cycles after the first; pulses at slots 0,1 of frame 1 and slots 0,8 of frame 2.
- Config change mid-frame: pulse_width changed 3->7 at cycle 25 of a 0xFF frame -> all pulses in that frame stay 3 wide; the next frame uses 7.
- Reset mid-frame: reset asserted at cycle 12 while out=1 -> out=0, busy=0 after that edge; in_ready=1 the cycle after reset deasserts; the next frame starts cleanly from the start slot.
